// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, rescale result type and round/saturate helper for FIR datapath blocks
package fir_pkg;

    localparam int FIR_DIN_W  = 18;
    localparam int FIR_DOUT_W = 8;

    // Rescaled value (zero-extended to 32 bits) plus saturation flag
    typedef struct packed {
        logic [31:0] value;
        logic        sat;
    } fir_rs_t;

    // Round-half-up right shift by shift bits, then clamp to dout_w bits.
    // The sum is kept one bit wider than the input so the rounding carry is never lost.
    function automatic fir_rs_t fir_round_sat(input logic [31:0] din, input int shift, input int dout_w);
        logic [32:0] r;
        logic [32:0] lim;
        fir_rs_t     res;
        r         = (shift == 0) ? {1'b0, din} : ({1'b0, din} + (33'd1 << (shift - 1))) >> shift;
        lim       = (33'd1 << dout_w) - 33'd1;
        res.sat   = r > lim;
        res.value = res.sat ? lim[31:0] : r[31:0];
        return res;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers
module fir_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Status from pointers; an extra wrap bit distinguishes full from empty
    always_comb begin
        empty_o  = wr_ptr_q == rd_ptr_q;
        full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        level_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    // Pointer registers; reset discards any stored contents
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write at the write index; blocked while reset is held
    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fir_output_stage.sv
// fir_output_stage: rescale FIR samples, buffer them and count saturations and overflow drops
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int DIN_W  = FIR_DIN_W,
    parameter int DOUT_W = FIR_DOUT_W,
    parameter int SHIFT  = 10,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DIN_W-1:0]          din,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DOUT_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          sat_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    fir_rs_t          rs;
    logic             full, empty, push, pop;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Rescale, handshakes and saturating counter next-state; the source never stalls, so full means drop
    always_comb begin
        rs         = fir_round_sat(32'(din), SHIFT, DOUT_W);
        push       = in_valid & ~full;
        pop        = ~empty & out_ready;
        sat_cnt_d  = (push && rs.sat && sat_cnt_q != '1) ? sat_cnt_q + CNT_W'(1) : sat_cnt_q;
        drop_cnt_d = (in_valid && full && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    end

    // Statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (DOUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (rs.value[DOUT_W-1:0]),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign sat_cnt   = sat_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: directed scoreboard bench for the FIR output stage
module tb_fir_output_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [17:0]   din = '0;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;
    logic [3:0]    level;
    logic [CW-1:0] sat_cnt;
    logic [CW-1:0] drop_cnt;

    int            checks = 0;
    int            errors = 0;
    bit            live = 1'b0;
    logic [7:0]    q[$];
    int            msat = 0;
    int            mdrop = 0;

    fir_output_stage #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .sat_cnt   (sat_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] resc(input int d);
        int r;
        r = (d + 512) / 1024;
        return (r > 255) ? {1'b1, 8'd255} : {1'b0, r[7:0]};
    endfunction

    task automatic step();
        int         n;
        bit         pop, push;
        logic [8:0] rv;
        n = q.size();
        if (live) begin
            chk("level", 32'(level), 32'(n));
            chk("in_ready", 32'(in_ready), 32'(n != 8));
            chk("out_valid", 32'(out_valid), 32'(n != 0));
            chk("out_data", 32'(out_data), (n != 0) ? 32'(q[0]) : 32'd0);
            chk("sat_cnt", 32'(sat_cnt), 32'(msat));
            chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        end
        pop  = (n != 0) && out_ready;
        push = in_valid && (n < 8);
        rv   = resc(int'(din));
        @(posedge clk);
        if (rst) begin
            q.delete();
            msat  = 0;
            mdrop = 0;
            live  = 1'b1;
        end else begin
            if (pop) q.delete(0);
            if (push) begin
                q.push_back(rv[7:0]);
                if (rv[8] && msat != 15) msat++;
            end
            if (in_valid && !push && mdrop != 15) mdrop++;
        end
        #1;
    endtask

    int rnd_in[4]  = '{511, 512, 1535, 1536};
    int rnd_exp[4] = '{0, 1, 1, 2};
    int sat_in[3]  = '{261631, 261632, 262143};

    initial begin
        // reset with a sample presented
        rst = 1'b1; in_valid = 1'b1; din = 18'd1000; out_ready = 1'b1;
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        step();
        // rounding
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; din = 18'(rnd_in[i]);
            step();
            chk("rnd_out", 32'(out_data), 32'(rnd_exp[i]));
        end
        in_valid = 1'b0;
        step(); step();
        chk("rnd_sat_cnt", 32'(sat_cnt), 32'd0);
        // saturation
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; din = 18'(sat_in[i]);
            step();
            chk("sat_out", 32'(out_data), 32'd255);
        end
        in_valid = 1'b0;
        step(); step();
        chk("sat_cnt_total", 32'(sat_cnt), 32'd2);
        // overflow with downstream stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; din = 18'(1024 * k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_order", 32'(out_data), 32'(i));
            step();
        end
        chk("ovf_drained", 32'(out_valid), 32'd0);
        // drop counter saturates at all-ones
        out_ready = 1'b0; in_valid = 1'b1; din = '0;
        for (int i = 0; i < 28; i++) step();
        in_valid = 1'b0;
        step();
        chk("drop_sat", 32'(drop_cnt), 32'd15);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        // concurrent push/pop at level 3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; din = 18'(1024 * (20 + i));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 18'(1024 * (23 + i));
            step();
            chk("cc_level", 32'(level), 32'd3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("cc_drained", 32'(out_valid), 32'd0);
        // mid-run reset
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; din = 18'(1024 * (40 + i));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("mid_level", 32'(level), 32'd5);
        rst = 1'b1; in_valid = 1'b1; din = 18'd5000;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sat", 32'(sat_cnt), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        step();
        chk("mid_not_stored", 32'(level), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
